// File: rtl/fmul_share_pkg.sv
// Shared types and helpers for the multiplier-sharing controller.
// Holds the tag-pipe entry layout and the round-robin pick function.
package fmul_share_pkg;

  localparam int FP_W      = 32;
  localparam int REQ_MAX   = 8;
  localparam int TAG_MAX_W = 3;

  typedef struct packed {
    logic                 valid;
    logic [TAG_MAX_W-1:0] tag;
  } tag_entry_t;

  // Lowest pending index strictly after last, wrapping; returns last when none pending.
  function automatic int rr_pick(input logic [REQ_MAX-1:0] valid, input int last, input int n);
    int   pick;
    int   idx;
    logic found;
    pick  = last;
    found = 1'b0;
    for (int off = 1; off <= REQ_MAX; off++) begin
      idx = (last + off) % n;
      if (!found && (off <= n) && valid[idx]) begin
        pick  = idx;
        found = 1'b1;
      end else begin
        pick  = pick;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/fmul_share_ctrl_rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant, registered last grant.
// The grant is forced low while reset is asserted.
module rr_arbiter
  import fmul_share_pkg::*;
#(
  parameter int N     = 4,
  parameter int TAG_W = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     valid,
  output logic [N-1:0]     grant,
  output logic [TAG_W-1:0] grant_idx,
  output logic             grant_any
);

  logic [REQ_MAX-1:0] valid_pad_s;
  logic [TAG_W-1:0]   last_grant_r;
  int                 pick_s;

  // Grant selection from pending requests and the previous winner
  always_comb begin
    valid_pad_s          = '0;
    valid_pad_s[N-1:0]   = valid;
    pick_s               = rr_pick(valid_pad_s, int'(last_grant_r), N);
    grant_idx            = TAG_W'(pick_s);
    grant_any            = rst_n && (valid != '0);
    grant                = '0;
    if (grant_any) begin
      grant[grant_idx] = 1'b1;
    end else begin
      grant = '0;
    end
  end

  // Remember the winner so the next grant starts after it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_r <= TAG_W'(N - 1);
    end else if (grant_any) begin
      last_grant_r <= grant_idx;
    end else begin
      last_grant_r <= last_grant_r;
    end
  end

endmodule

// File: rtl/fmul_share_ctrl.sv
// Shares one fixed-latency pipelined multiplier among several requesters.
// A tag pipe matching the multiplier latency routes each result back to its owner.
module fmul_share_ctrl
  import fmul_share_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int MUL_LATENCY = 3,
  parameter int TAG_W       = $clog2(NUM_REQ)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_REQ-1:0]      req_valid,
  input  logic [NUM_REQ*FP_W-1:0] req_a,
  input  logic [NUM_REQ*FP_W-1:0] req_b,
  output logic [NUM_REQ-1:0]      req_ready,
  output logic [NUM_REQ-1:0]      resp_valid,
  output logic [FP_W-1:0]         resp_data,
  output logic [FP_W-1:0]         mul_a,
  output logic [FP_W-1:0]         mul_b,
  input  logic [FP_W-1:0]         mul_f,
  output logic                    mul_rst,
  output logic [2:0]              inflight
);

  localparam int STAGES = MUL_LATENCY + 1;

  logic [NUM_REQ-1:0] grant_s;
  logic [TAG_W-1:0]   grant_idx_s;
  logic               grant_any_s;
  tag_entry_t         pipe_r [STAGES];
  tag_entry_t         last_s;
  logic [NUM_REQ-1:0] resp_onehot_s;
  logic [2:0]         inflight_r;

  rr_arbiter #(.N(NUM_REQ), .TAG_W(TAG_W)) u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .valid     (req_valid),
    .grant     (grant_s),
    .grant_idx (grant_idx_s),
    .grant_any (grant_any_s)
  );

  assign req_ready = grant_s;
  assign mul_rst   = ~rst_n;
  assign inflight  = inflight_r;

  // Decode the final tag-pipe stage into a one-hot response vector
  always_comb begin
    last_s        = pipe_r[STAGES-1];
    resp_onehot_s = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      resp_onehot_s[i] = last_s.valid && (last_s.tag == TAG_MAX_W'(i));
    end
  end

  // Operand registers feeding the multiplier; hold when nothing is granted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mul_a <= '0;
      mul_b <= '0;
    end else if (grant_any_s) begin
      mul_a <= req_a[FP_W*grant_idx_s +: FP_W];
      mul_b <= req_b[FP_W*grant_idx_s +: FP_W];
    end else begin
      mul_a <= mul_a;
      mul_b <= mul_b;
    end
  end

  // Tag shift pipe; the last stage lines up with a valid mul_f
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < STAGES; i++) begin
        pipe_r[i] <= '0;
      end
    end else begin
      pipe_r[0].valid <= grant_any_s;
      pipe_r[0].tag   <= grant_any_s ? TAG_MAX_W'(grant_idx_s) : '0;
      for (int i = 1; i < STAGES; i++) begin
        pipe_r[i] <= pipe_r[i-1];
      end
    end
  end

  // Response register; mul_f is only captured when a tagged result is due
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_valid <= '0;
      resp_data  <= '0;
    end else if (last_s.valid) begin
      resp_valid <= resp_onehot_s;
      resp_data  <= mul_f;
    end else begin
      resp_valid <= '0;
      resp_data  <= resp_data;
    end
  end

  // Outstanding-operation counter, tracked incrementally
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight_r <= 3'd0;
    end else begin
      case ({grant_any_s, (resp_valid != '0)})
        2'b10:   inflight_r <= inflight_r + 3'd1;
        2'b01:   inflight_r <= inflight_r - 3'd1;
        default: inflight_r <= inflight_r;
      endcase
    end
  end

endmodule

// File: tb/tb_fmul_share_ctrl.sv
// Directed self-checking bench for fmul_share_ctrl with a 3-stage multiplier model.
module tb_fmul_share_ctrl;

  localparam int N = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [N-1:0]  req_valid = '0;
  logic [N*32-1:0] req_a = '0;
  logic [N*32-1:0] req_b = '0;
  logic [N-1:0]  req_ready;
  logic [N-1:0]  resp_valid;
  logic [31:0]   resp_data;
  logic [31:0]   mul_a;
  logic [31:0]   mul_b;
  logic [31:0]   mul_f;
  logic          mul_rst;
  logic [2:0]    inflight;

  logic [31:0]   s1_r, s2_r, f_r;
  logic          force_dead = 1'b0;

  int checks = 0;
  int failures = 0;

  fmul_share_ctrl #(.NUM_REQ(N), .MUL_LATENCY(3)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_ready  (req_ready),
    .resp_valid (resp_valid),
    .resp_data  (resp_data),
    .mul_a      (mul_a),
    .mul_b      (mul_b),
    .mul_f      (mul_f),
    .mul_rst    (mul_rst),
    .inflight   (inflight)
  );

  always #5 clk = ~clk;

  // Hand-computed products for the operand pairs the bench uses
  function automatic logic [31:0] fp_prod(input logic [31:0] a, input logic [31:0] b);
    logic [63:0] ab;
    ab = {a, b};
    case (ab)
      64'h40000000_40400000: return 32'h40C00000;
      64'h3FC00000_3FC00000: return 32'h40100000;
      64'h40000000_40000000: return 32'h40800000;
      default:               return 32'h7FC00000;
    endcase
  endfunction

  // Multiplier model: F valid three edges after an operand change, never reset
  always @(posedge clk) begin
    s1_r <= fp_prod(mul_a, mul_b);
    s2_r <= s1_r;
    f_r  <= s2_r;
  end

  assign mul_f = force_dead ? 32'hDEADBEEF : f_r;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_ops(input logic [31:0] a, input logic [31:0] b);
    for (int i = 0; i < N; i++) begin
      req_a[32*i +: 32] = a;
      req_b[32*i +: 32] = b;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    req_valid = '0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Hold vmask for n cycles; check grants and the response stream 5 negedges later
  task automatic burst(input logic [3:0] vmask, input int n, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] prod, input string tag);
    logic [3:0] eg;
    int j;
    set_ops(a, b);
    for (int k = 0; k < n + 6; k++) begin
      @(negedge clk);
      req_valid = (k < n) ? vmask : 4'b0000;
      #1;
      if (k < n) begin
        eg = (vmask == 4'hF) ? (4'b0001 << (k % 4)) : vmask;
        check_val($sformatf("%s_ready%0d", tag, k), req_ready, eg);
      end
      j = k - 5;
      if (j >= 0 && j < n) begin
        eg = (vmask == 4'hF) ? (4'b0001 << (j % 4)) : vmask;
        check_val($sformatf("%s_resp%0d", tag, j), resp_valid, eg);
        check_val($sformatf("%s_data%0d", tag, j), resp_data, prod);
      end else begin
        check_val($sformatf("%s_noresp%0d", tag, k), resp_valid, 32'd0);
      end
    end
    check_val($sformatf("%s_inflight_end", tag), inflight, 32'd0);
  endtask

  initial begin
    logic [3:0] em;
    int j;

    // Reset state, with requests pending that must not be granted
    req_valid = 4'hF;
    @(negedge clk);
    #1;
    check_val("rst_ready", req_ready, 32'd0);
    check_val("rst_resp_valid", resp_valid, 32'd0);
    check_val("rst_resp_data", resp_data, 32'd0);
    check_val("rst_mul_a", mul_a, 32'd0);
    check_val("rst_mul_b", mul_b, 32'd0);
    check_val("rst_inflight", inflight, 32'd0);
    check_val("rst_mul_rst", mul_rst, 32'd1);
    req_valid = 4'h0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_val("rel_mul_rst", mul_rst, 32'd0);

    // Single op from req0: 2.0 x 3.0
    burst(4'b0001, 1, 32'h40000000, 32'h40400000, 32'h40C00000, "t1");
    check_val("t1_mul_a_hold", mul_a, 32'h40000000);
    check_val("t1_mul_b_hold", mul_b, 32'h40400000);

    // All four requesters, 1.5 x 1.5, from a fresh round-robin pointer
    do_reset();
    burst(4'hF, 8, 32'h3FC00000, 32'h3FC00000, 32'h40100000, "t2");

    // Only req2, continuous
    burst(4'b0100, 10, 32'h40000000, 32'h40000000, 32'h40800000, "t3");

    // Accept req3 then req1, then reset before their results return
    @(negedge clk);
    req_valid = 4'b1010;
    #1;
    check_val("t4_grant_first", req_ready, 32'h8);
    @(negedge clk);
    #1;
    check_val("t4_grant_second", req_ready, 32'h2);
    @(negedge clk);
    req_valid = 4'b0000;
    rst_n = 1'b0;
    #1;
    check_val("t4_rst_inflight", inflight, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    req_valid = 4'b1011;
    #1;
    check_val("t4_post_rst_grant", req_ready, 32'h1);
    req_valid = 4'b0000;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check_val($sformatf("t4_noresp%0d", k), resp_valid, 32'd0);
    end
    check_val("t4_inflight_end", inflight, 32'd0);

    // Idle with a garbage multiplier output
    do_reset();
    force_dead = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      check_val($sformatf("t5_idle%0d", k), resp_valid, 32'd0);
    end
    check_val("t5_data", resp_data, 32'd0);
    force_dead = 1'b0;

    // req0 and req1 take turns, one request every other cycle
    set_ops(32'h40000000, 32'h40400000);
    for (int k = 0; k < 18; k++) begin
      @(negedge clk);
      em = (k < 12 && (k % 2) == 0) ? (((k % 4) == 0) ? 4'b0001 : 4'b0010) : 4'b0000;
      req_valid = em;
      #1;
      if (em != 4'b0000) begin
        check_val($sformatf("t6_ready%0d", k), req_ready, em);
      end
      check_val($sformatf("t6_inflight_le4_%0d", k), (inflight <= 3'd4), 32'd1);
      j = k - 5;
      if (j >= 0 && j < 12 && (j % 2) == 0) begin
        em = ((j % 4) == 0) ? 4'b0001 : 4'b0010;
        check_val($sformatf("t6_resp%0d", j), resp_valid, em);
        check_val($sformatf("t6_data%0d", j), resp_data, 32'h40C00000);
      end else begin
        check_val($sformatf("t6_noresp%0d", k), resp_valid, 32'd0);
      end
    end
    check_val("t6_inflight_end", inflight, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
